// File: rtl/reg_alu_datapath.sv
// reg_alu_datapath: five-register file with a change-triggered ALU stage.
// A new control word is latched, then executed exactly once on the next edge.
module reg_alu_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_reset,
    input  logic [WIDTH-1:0] immediate,
    input  logic [NREGS-1:0] regEnables,
    input  logic [NREGS-1:0] buffAEnables,
    input  logic [NREGS-1:0] buffBEnables,
    input  logic             Cin,
    input  logic             regOrImmed,
    input  logic [3:0]       op,
    input  logic [3:0]       exop,
    input  logic [2:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             done
);
    localparam int CWW = WIDTH + 3*NREGS + 10;
    localparam int OBB = 10;
    localparam int OBA = OBB + NREGS;
    localparam int ORE = OBA + NREGS;
    localparam int OIM = ORE + NREGS;

    localparam logic [3:0] F_AND = 4'b0001;
    localparam logic [3:0] F_OR  = 4'b0010;
    localparam logic [3:0] F_XOR = 4'b0011;
    localparam logic [3:0] F_LSH = 4'b0100;
    localparam logic [3:0] F_ADD = 4'b0101;
    localparam logic [3:0] F_RSH = 4'b1000;
    localparam logic [3:0] F_SUB = 4'b1001;
    localparam logic [3:0] F_CMP = 4'b1011;
    localparam logic [3:0] F_MOV = 4'b1101;

    logic [CWW-1:0]   w_cw;
    logic [CWW-1:0]   r_cw_q;
    logic             r_exec_q;
    logic             r_done;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_flags;

    logic [3:0]       w_op, w_exop, w_func;
    logic             w_roi, w_cin;
    logic [NREGS-1:0] w_bb, w_ba, w_re;
    logic [WIDTH-1:0] w_imm, w_a, w_b, w_breg, w_val;
    logic [WIDTH:0]   w_sum, w_diff;
    logic             w_wb, w_nz, w_ar, w_lu, w_c, w_f;

    assign w_cw = {immediate, regEnables, buffAEnables, buffBEnables,
                   Cin, regOrImmed, op, exop};

    assign w_exop = r_cw_q[3:0];
    assign w_op   = r_cw_q[7:4];
    assign w_roi  = r_cw_q[8];
    assign w_cin  = r_cw_q[9];
    assign w_bb   = r_cw_q[OBB +: NREGS];
    assign w_ba   = r_cw_q[OBA +: NREGS];
    assign w_re   = r_cw_q[ORE +: NREGS];
    assign w_imm  = r_cw_q[OIM +: WIDTH];

    always_comb begin
        w_a    = '0;
        w_breg = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (w_ba[i]) w_a = w_a | r_regs[i];
            if (w_bb[i]) w_breg = w_breg | r_regs[i];
        end
    end

    assign w_b    = (w_roi || w_op != 4'b0000) ? w_imm : w_breg;
    assign w_func = (w_op == 4'b0000) ? w_exop : w_op;
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b} - {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        w_val = '0;
        w_wb  = 1'b0;
        w_nz  = 1'b0;
        w_ar  = 1'b0;
        w_lu  = 1'b0;
        w_c   = 1'b0;
        w_f   = 1'b0;
        case (w_func)
            F_AND: begin w_val = w_a & w_b; w_wb = 1'b1; w_nz = 1'b1; end
            F_OR:  begin w_val = w_a | w_b; w_wb = 1'b1; w_nz = 1'b1; end
            F_XOR: begin w_val = w_a ^ w_b; w_wb = 1'b1; w_nz = 1'b1; end
            F_MOV: begin w_val = w_b; w_wb = 1'b1; w_nz = 1'b1; end
            F_LSH: begin w_val = w_a << w_b[3:0]; w_wb = 1'b1; w_nz = 1'b1; end
            F_RSH: begin w_val = w_a >> w_b[3:0]; w_wb = 1'b1; w_nz = 1'b1; end
            F_ADD: begin
                w_val = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_f   = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                        (w_val[WIDTH-1] != w_a[WIDTH-1]);
                w_wb  = 1'b1;
                w_nz  = 1'b1;
                w_ar  = 1'b1;
            end
            F_SUB, F_CMP: begin
                // C holds the borrow out of the subtraction
                w_val = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_f   = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                        (w_val[WIDTH-1] != w_a[WIDTH-1]);
                w_wb  = (w_func == F_SUB);
                w_nz  = 1'b1;
                w_ar  = 1'b1;
                w_lu  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cw_q   <= '0;
            r_exec_q <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (ctrl_reset) begin
            r_cw_q   <= '0;
            r_exec_q <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_cw_q   <= w_cw;
            r_exec_q <= (w_cw != r_cw_q);
            r_done   <= r_exec_q;
            if (r_exec_q) begin
                if (w_wb) begin
                    r_result <= w_val;
                    for (int i = 0; i < NREGS; i++)
                        if (w_re[i]) r_regs[i] <= w_val;
                end
                if (w_nz) begin
                    r_flags[1] <= (w_val == '0);
                    r_flags[0] <= w_val[WIDTH-1];
                end
                if (w_ar) begin
                    r_flags[4] <= w_c;
                    r_flags[2] <= w_f;
                end
                if (w_lu) r_flags[3] <= (w_a < w_b);
            end
        end
    end

    always_comb begin
        dbg_data = '0;
        for (int i = 0; i < NREGS; i++)
            if (int'(dbg_sel) == i) dbg_data = r_regs[i];
    end

    assign result = r_result;
    assign flags  = r_flags;
    assign done   = r_done;

endmodule

// File: tb/tb_reg_alu_datapath.sv
// Bench for reg_alu_datapath: directed cases plus random control words
// checked against an arithmetic model of the register file and ALU.
module tb_reg_alu_datapath;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_reset = 1'b0;
    logic [15:0] immediate = '0;
    logic [4:0]  regEnables = '0, buffAEnables = '0, buffBEnables = '0;
    logic        Cin = 1'b0, regOrImmed = 1'b0;
    logic [3:0]  op = '0, exop = '0;
    logic [2:0]  dbg_sel = '0;
    logic [15:0] dbg_data, result;
    logic [4:0]  flags;
    logic        done;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_r [5];
    logic [15:0] m_res;
    logic [4:0]  m_fl;
    logic [40:0] m_cw;

    reg_alu_datapath dut (
        .clk(clk), .reset(reset), .ctrl_reset(ctrl_reset),
        .immediate(immediate), .regEnables(regEnables),
        .buffAEnables(buffAEnables), .buffBEnables(buffBEnables),
        .Cin(Cin), .regOrImmed(regOrImmed), .op(op), .exop(exop),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .result(result),
        .flags(flags), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 5; i++) m_r[i] = '0;
        m_res = '0;
        m_fl  = '0;
        m_cw  = '0;
    endtask

    // Model: flags are {C, L, F, Z, N}
    task automatic m_exec();
        logic [15:0] a, b, v;
        int fn, s, sv;
        bit wb, nz;
        a = '0;
        b = '0;
        v = '0;
        for (int i = 0; i < 5; i++) if (buffAEnables[i]) a |= m_r[i];
        if (regOrImmed || op != 4'd0) b = immediate;
        else for (int i = 0; i < 5; i++) if (buffBEnables[i]) b |= m_r[i];
        fn = (op == 4'd0) ? int'(exop) : int'(op);
        wb = 1;
        nz = 1;
        case (fn)
            1: v = a & b;
            2: v = a | b;
            3: v = a ^ b;
            4: v = 16'(a << b[3:0]);
            8: v = a >> b[3:0];
            13: v = b;
            5: begin
                s = int'(a) + int'(b) + int'(Cin);
                v = 16'(s);
                m_fl[4] = (s > 65535);
                sv = int'($signed(a)) + int'($signed(b)) + int'(Cin);
                m_fl[2] = (sv > 32767) || (sv < -32768);
            end
            9, 11: begin
                s = int'(a) - int'(b) - int'(Cin);
                v = 16'(s);
                m_fl[4] = (s < 0);
                sv = int'($signed(a)) - int'($signed(b)) - int'(Cin);
                m_fl[2] = (sv > 32767) || (sv < -32768);
                m_fl[3] = (a < b);
                if (fn == 11) wb = 0;
            end
            default: begin wb = 0; nz = 0; end
        endcase
        if (nz) begin
            m_fl[1] = (v == 16'd0);
            m_fl[0] = v[15];
        end
        if (wb) begin
            m_res = v;
            for (int i = 0; i < 5; i++) if (regEnables[i]) m_r[i] = v;
        end
    endtask

    task automatic set_cw(input logic [15:0] imm, input logic [4:0] re,
                          input logic [4:0] ba, input logic [4:0] bb,
                          input logic c, input logic roi,
                          input logic [3:0] o, input logic [3:0] e,
                          output bit ex);
        logic [40:0] cwv;
        immediate = imm; regEnables = re;
        buffAEnables = ba; buffBEnables = bb;
        Cin = c; regOrImmed = roi; op = o; exop = e;
        cwv = {imm, re, ba, bb, c, roi, o, e};
        ex = (cwv != m_cw);
        m_cw = cwv;
        if (ex) m_exec();
    endtask

    task automatic chk_state(input string tag);
        for (int i = 0; i < 5; i++) begin
            dbg_sel = 3'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(m_r[i]));
        end
        dbg_sel = 3'd5;
        #1;
        chk({tag, "_dbg5"}, 32'(dbg_data), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'(m_res));
        chk({tag, "_flags"}, 32'(flags), 32'(m_fl));
    endtask

    task automatic issue(input string tag, input logic [15:0] imm,
                         input logic [4:0] re, input logic [4:0] ba,
                         input logic [4:0] bb, input logic c,
                         input logic roi, input logic [3:0] o,
                         input logic [3:0] e);
        bit ex;
        @(negedge clk);
        set_cw(imm, re, ba, bb, c, roi, o, e, ex);
        @(posedge clk); #1;
        chk({tag, "_done_e0"}, 32'(done), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_e1"}, 32'(done), 32'(ex));
        chk_state(tag);
    endtask

    initial begin
        bit ex;
        int cnt;
        m_clear();

        #12;
        chk("rst_done", 32'(done), 32'd0);
        chk_state("rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_done", 32'(done), 32'd0);

        // MOV r1 = 5
        issue("mov", 16'd5, 5'b00010, 5'b0, 5'b0, 1'b0, 1'b0, 4'b1101, 4'b0);
        chk("mov_r1", 32'(m_r[1]), 32'd5);
        issue("mov8", 16'd8, 5'b00100, 5'b0, 5'b0, 1'b0, 1'b0, 4'b1101, 4'b0);
        // r3 = r1 + r2 + 1
        issue("addr", 16'd0, 5'b01000, 5'b00010, 5'b00100, 1'b1, 1'b0,
              4'b0000, 4'b0101);
        dbg_sel = 3'd3; #1;
        chk("addr_r3_14", 32'(dbg_data), 32'd14);
        issue("movff", 16'hFFFF, 5'b00010, 5'b0, 5'b0, 1'b0, 1'b0,
              4'b1101, 4'b0);
        issue("addwrap", 16'd1, 5'b00001, 5'b00010, 5'b0, 1'b0, 1'b0,
              4'b0101, 4'b0);
        chk("addwrap_res", 32'(result), 32'd0);
        chk("addwrap_CZ", 32'({flags[4], flags[1]}), 32'b11);

        // CMP 3 vs 5
        issue("mov3", 16'd3, 5'b00010, 5'b0, 5'b0, 1'b0, 1'b0, 4'b1101, 4'b0);
        issue("cmp", 16'd5, 5'b00010, 5'b00010, 5'b0, 1'b0, 1'b0,
              4'b1011, 4'b0);
        chk("cmp_flags", 32'(flags), 32'b11001);
        chk("cmp_res", 32'(result), 32'd3);
        issue("mov8k", 16'h8000, 5'b00010, 5'b0, 5'b0, 1'b0, 1'b0,
              4'b1101, 4'b0);
        issue("sub", 16'd1, 5'b00001, 5'b00010, 5'b0, 1'b0, 1'b0,
              4'b1001, 4'b0);
        chk("sub_res", 32'(result), 32'h7FFF);
        chk("sub_F", 32'(flags[2]), 32'd1);

        // Held CW: r1 = r1 + r1 for 1000 cycles
        issue("mov3b", 16'd3, 5'b00010, 5'b0, 5'b0, 1'b0, 1'b0, 4'b1101, 4'b0);
        @(negedge clk);
        set_cw(16'd0, 5'b00010, 5'b00010, 5'b00010, 1'b0, 1'b0,
               4'b0000, 4'b0101, ex);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("held_pulses", 32'(cnt), 32'd1);
        chk_state("held");
        chk("held_r1_6", 32'(m_r[1]), 32'd6);

        // Back-to-back: each change executes in order
        @(negedge clk);
        set_cw(16'd7, 5'b00001, 5'b0, 5'b0, 1'b0, 1'b0, 4'b1101, 4'b0, ex);
        @(posedge clk);
        @(negedge clk);
        set_cw(16'd3, 5'b00001, 5'b00001, 5'b0, 1'b0, 1'b0, 4'b0101, 4'b0, ex);
        @(posedge clk); #1;
        chk("b2b_d1", 32'(done), 32'd1);
        @(negedge clk);
        set_cw(16'h00F0, 5'b10000, 5'b00001, 5'b0, 1'b0, 1'b0,
               4'b0011, 4'b0, ex);
        @(posedge clk); #1;
        chk("b2b_d2", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("b2b_d3", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("b2b_d4", 32'(done), 32'd0);
        chk_state("b2b");
        chk("b2b_r4", 32'(m_r[4]), 32'h00FA);

        // ctrl_reset drops the pending execute
        @(negedge clk);
        set_cw(16'h1234, 5'b10000, 5'b0, 5'b0, 1'b0, 1'b0, 4'b1101, 4'b0, ex);
        @(posedge clk);
        @(negedge clk);
        ctrl_reset = 1'b1;
        m_clear();
        @(posedge clk); #1;
        chk("crst_done", 32'(done), 32'd0);
        chk("crst_r4", 32'(dbg_data), 32'd0);
        chk("crst_res", 32'(result), 32'd0);
        @(posedge clk); #1;
        chk("crst_hold_done", 32'(done), 32'd0);
        @(negedge clk);
        ctrl_reset = 1'b0;
        set_cw(16'h1234, 5'b10000, 5'b0, 5'b0, 1'b0, 1'b0, 4'b1101, 4'b0, ex);
        @(posedge clk); #1;
        chk("crel_d0", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("crel_d1", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("crel_d2", 32'(done), 32'd0);
        chk_state("crel");
        chk("crel_r4", 32'(m_r[4]), 32'h1234);

        // Random control words, some repeated
        for (int n = 0; n < 60; n++) begin
            if (n > 0 && $urandom_range(0, 4) == 0)
                issue("rnd_rep", immediate, regEnables, buffAEnables,
                      buffBEnables, Cin, regOrImmed, op, exop);
            else
                issue("rnd", 16'($urandom), 5'($urandom), 5'($urandom),
                      5'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom),
                      4'($urandom));
        end

        // Async reset with an execute pending
        @(negedge clk);
        set_cw(16'h5A5A, 5'b11111, 5'b0, 5'b0, 1'b0, 1'b0, 4'b1101, 4'b0, ex);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        m_clear();
        chk("arst_done", 32'(done), 32'd0);
        chk_state("arst");
        immediate = '0; regEnables = '0; buffAEnables = '0;
        buffBEnables = '0; Cin = 1'b0; regOrImmed = 1'b0;
        op = '0; exop = '0;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("arst_zero_cw", 32'(cnt), 32'd0);
        chk_state("arst_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
